// File: rtl/ltch_wr_sequencer.sv
// ltch_wr_sequencer: valid/ready write sequencer driving a latch array with setup -> open -> hold ordering.
// Latch enables and shared data are both flop outputs, so enables are glitch-free pulses with stable data on either side.
module ltch_wr_sequencer #(
    parameter int DW = 32,
    parameter int NE = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] ltch_dnxt,
    output logic [NE-1:0] ltch_lden,
    output logic          busy,
    output logic          wr_done,
    output logic          wr_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [NE-1:0] lden_nxt;
    logic          accept, addr_ok;

    assign wr_ready = (state == IDLE) && !rst;
    assign busy     = state != IDLE;
    assign accept   = wr_valid && wr_ready;
    // One extra bit so NE == 2**AW compares correctly
    assign addr_ok  = {1'b0, addr_q} < (AW+1)'(NE);

    // Out-of-range addresses match no entry, so the enable stays low
    for (genvar i = 0; i < NE; i++) begin : g_lden
        assign lden_nxt[i] = (state == SETUP) && (addr_q == AW'(i));
    end

    always_comb begin
        state_nxt = state == IDLE  ? (accept ? SETUP : IDLE) :
                    state == SETUP ? LOAD :
                    state == LOAD  ? HOLD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            ltch_dnxt <= '0;
            ltch_lden <= '0;
            wr_done   <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ltch_lden <= lden_nxt;
            wr_err    <= (state == SETUP) && !addr_ok;
            wr_done   <= state == LOAD;
            if (accept) begin
                addr_q    <= wr_addr;
                ltch_dnxt <= wr_data;
            end
        end
    end

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
    always @(posedge clk) begin
        if (!rst && $isunknown(wr_valid))
            $fatal(1, "ltch_wr_sequencer: wr_valid is X outside reset");
        if (!rst)
            assert ($onehot0(ltch_lden)) else $error("ltch_wr_sequencer: more than one latch enable high");
    end
`endif
`endif
endmodule

// File: tb/tb_ltch_wr_sequencer.sv
// tb_ltch_wr_sequencer: directed and random checks on an 8-entry and a 6-entry sequencer driven in parallel.
module tb_ltch_wr_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rdy8, busy8, done8, err8, rdy6, busy6, done6, err6;
    logic [31:0] dn8, dn6;
    logic [7:0]  ld8;
    logic [5:0]  ld6;
    logic [31:0] mem8 [8];
    logic [31:0] exp8 [8];
    logic [31:0] mem6 [6];
    logic [31:0] exp6 [6];
    logic        mem_init = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ltch_wr_sequencer #(.DW(32), .NE(8), .AW(3)) u_dut8 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy8), .wr_addr(wr_addr),
        .wr_data(wr_data), .ltch_dnxt(dn8), .ltch_lden(ld8), .busy(busy8),
        .wr_done(done8), .wr_err(err8)
    );

    ltch_wr_sequencer #(.DW(32), .NE(6), .AW(3)) u_dut6 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy6), .wr_addr(wr_addr),
        .wr_data(wr_data), .ltch_dnxt(dn6), .ltch_lden(ld6), .busy(busy6),
        .wr_done(done6), .wr_err(err6)
    );

    // Behavioural latch arrays fed by the DUT outputs
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 8; i++) mem8[i] <= '0;
            for (int i = 0; i < 6; i++) mem6[i] <= '0;
            mem_init <= 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) if (ld8[i]) mem8[i] <= dn8;
            for (int i = 0; i < 6; i++) if (ld6[i]) mem6[i] <= dn6;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input bit keep);
        logic [7:0] l8;
        logic [5:0] l6;
        bit         bad6;
        l8   = 8'(1) << a;
        bad6 = a >= 3'd6;
        l6   = bad6 ? 6'd0 : 6'(8'(1) << a);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check("idle_ready8", rdy8, 1);
        check("idle_ready6", rdy6, 1);
        step();
        wr_valid = keep;
        wr_addr  = ~a;
        wr_data  = ~d;
        check("setup_dnxt8", dn8, d);
        check("setup_dnxt6", dn6, d);
        check("setup_lden8", ld8, 0);
        check("setup_lden6", ld6, 0);
        check("setup_busy8", busy8, 1);
        check("setup_ready8", rdy8, 0);
        step();
        check("load_lden8", ld8, l8);
        check("load_lden6", ld6, l6);
        check("load_dnxt8", dn8, d);
        check("load_dnxt6", dn6, d);
        check("load_err8", err8, 0);
        check("load_err6", err6, bad6);
        check("load_done8", done8, 0);
        check("load_ready6", rdy6, 0);
        step();
        check("hold_lden8", ld8, 0);
        check("hold_lden6", ld6, 0);
        check("hold_done8", done8, 1);
        check("hold_done6", done6, 1);
        check("hold_err6", err6, 0);
        check("hold_dnxt8", dn8, d);
        check("hold_dnxt6", dn6, d);
        check("hold_ready8", rdy8, 0);
        step();
        check("ret_done8", done8, 0);
        check("ret_ready8", rdy8, 1);
        check("ret_busy8", busy8, 0);
        check("ret_busy6", busy6, 0);
        check("ret_dnxt8", dn8, d);
        exp8[a] = d;
        if (!bad6) exp6[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp8[i] = '0;
        for (int i = 0; i < 6; i++) exp6[i] = '0;
        #2;
        check("rst_ready8", rdy8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_lden8", ld8, 0);
        check("rst_dnxt8", dn8, 0);
        check("rst_done8", done8, 0);
        check("rst_err8", err8, 0);
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("quiet_ready", rdy8, 1);
            check("quiet_busy", busy8, 0);
            check("quiet_lden", ld8, 0);
            check("quiet_dnxt", dn8, 0);
            step();
        end
        do_write(3'd5, 32'hDEADBEEF, 1'b0);
        do_write(3'd0, 32'h11110000, 1'b1);
        do_write(3'd1, 32'h22221111, 1'b1);
        do_write(3'd2, 32'h44442222, 1'b0);
        do_write(3'd7, 32'hCAFE0007, 1'b0);
        wr_valid = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 32'h33333333;
        step();
        wr_valid = 1'b0;
        step();
        check("midrst_pre_lden8", ld8, 8'h08);
        #2 rst = 1'b1;
        #1;
        check("midrst_lden8", ld8, 0);
        check("midrst_lden6", ld6, 0);
        check("midrst_dnxt8", dn8, 0);
        check("midrst_ready8", rdy8, 0);
        check("midrst_busy8", busy8, 0);
        step();
        check("midrst_done8", done8, 0);
        step();
        check("midrst_done6", done6, 0);
        #2 rst = 1'b0;
        step();
        check("postrst_ready8", rdy8, 1);
        check("postrst_dnxt8", dn8, 0);
        do_write(3'd3, 32'h3C3C3C3C, 1'b0);
        for (int i = 0; i < 8; i++) do_write(3'(i), 32'hA5000000 | 32'(i), 1'b0);
        for (int i = 0; i < 150; i++)
            do_write(3'($urandom_range(7)), $urandom, 1'($urandom_range(1)));
        wr_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 8; i++) check("array8", mem8[i], exp8[i]);
        for (int i = 0; i < 6; i++) check("array6", mem6[i], exp6[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
